qoi_stream_port: RTL and testbench
==================================

# qoi_stream_port

Memory-mapped output port that sits on the `cpu_65c02` data bus in the QOI output window (0x9000–0x9FFF) and replaces the plain QOI buffer RAM. It accepts the encoded QOI byte stream that the 6502 encoder firmware writes, buffers it in a FIFO, and drains it on a valid/ready byte stream toward the downstream sink. It also counts the bytes and detects the QOI end marker (seven 0x00 bytes followed by 0x01) so the stream closes with `m_last`.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  window select, decoded outside the block from `AB` (0x9000–0x9FFF).
- `addr`  in  2  `AB[1:0]`, register select.
- `we`  in  1  CPU `WE`.
- `wdata`  in  8  CPU `DO`.
- `rdata`  out  8  registered read data, muxed onto CPU `DI`.
- `m_data`  out  8  stream byte.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  sink accepts the byte.
- `m_last`  out  1  the current byte is the 0x01 that terminates the end marker.
- `irq`  out  1  level interrupt (see Configuration).

## Operation
- Register map, read:
  - 0 DATA: reads 0x00.
  - 1 STATUS: {irq_en, 2'b0, ovf, done, empty, full, 1'b0} as bit7..bit0. Bit7 = irq_en, bit4 = ovf, bit3 = done, bit2 = empty, bit1 = full.
  - 2 CNT_LO.
  - 3 CNT_HI shadow.
- Register map, write:
  - 0 DATA: pushes `wdata`.
  - 1 CTRL: bit0 writes irq_en. Bit7 = 1 flushes: empties the FIFO and clears count, zero run, done, ovf, and shadow. irq_en takes bit0 in the same write.
  - 2 and 3: ignored.
- Push: `cs & we & addr==0`.
  - When not full, stores {last_flag, wdata}.
  - When full, the byte is dropped and ovf is set (sticky). Count is not incremented.
  - Full is evaluated on the pre-edge state; a same-cycle pop does not admit the push.
- Byte count: 16-bit counter of accepted pushes. Wraps 0xFFFF→0x0000.
- End-marker detect:
  - 3-bit zero-run counter on accepted pushes. 0x00 increments it, saturating at 7. Any other byte clears it.
  - last_flag = (wdata==0x01 && run==7).
  - More than 7 zeros before 0x01 still qualifies.
  - Dropped bytes do not affect the run.
- Pop: `m_valid & m_ready`. `m_data`/`m_last` come from the FIFO head. `m_valid` = !empty.
- done sets on the pop of an entry with last = 1. It stays set until flush or reset.
- Reading CNT_LO returns the live low byte and copies the live high byte into the shadow in the same cycle. CNT_HI returns the shadow.
- A flush does not interrupt the sink handshake rules. Because `m_valid` drops with the FIFO, a pending byte is discarded.

## Timing
- Reset values:
  - `rdata` = 0x00, `m_valid` = 0, `m_last` = 0, `m_data` = 0x00, `irq` = 0.
  - FIFO empty; count, run, done, ovf, irq_en, shadow all 0.
- Read latency is 1 cycle: `rdata` is updated on the edge that samples `cs & ~we` and holds otherwise. STATUS reflects pre-edge state.
- Push-to-output latency is 1 cycle: an accepted push into an empty FIFO gives `m_valid` = 1 after that edge.
- Sustained throughput is 1 byte/cycle in and out. Simultaneous push and pop with the FIFO neither full nor empty leaves occupancy unchanged.
- `m_data`/`m_last` are held stable while `m_valid & ~m_ready`.
- Pointers are log2(DEPTH) bits plus a wrap bit. full = occupancy == DEPTH.
- Flush takes effect on its write edge. A same-cycle pop is ignored.
- Async reset mid-stream clears everything immediately; `m_valid` drops without a handshake.

## Configuration
- `QOI_STREAM_PORT_IRQ_EN` defined: `irq` = irq_en & done, registered, asserting the cycle after done sets. Firmware clears it by flush or by writing irq_en = 0.
- Not defined: `irq` is tied 0. The irq_en bit is still writable and readable in STATUS bit7, but has no effect.

## Test plan
- Reset, then read STATUS → 0x04. Read CNT_LO/CNT_HI → 0x00/0x00. `m_valid` = 0.
- With `m_ready` = 0, push 0xAA, 0xBB → after the second edge, `m_valid` = 1 and `m_data` = 0xAA. Raise `m_ready` → 0xAA then 0xBB on consecutive cycles, then `m_valid` = 0. CNT_LO = 0x02.
- `DEPTH` = 16, `m_ready` = 0, push 17 bytes → STATUS = 0x12 (full, ovf). Count = 16. The 17th byte never appears on the stream.
- Push 0x10, 8×0x00, 0x01 → `m_last` = 1 only on the 0x01 byte. STATUS done bit set after its pop. `irq` = 1 one cycle later with the macro and irq_en = 1; 0 without the macro.
- Push 0x00×6, 0x01 → no `m_last`. Push 0x00×7, 0x05, 0x01 → no `m_last`.
- Preload count to 0x00FF, read CNT_LO (0xFF), push one byte, read CNT_HI → 0x00 (shadow). Read CNT_LO → 0x00. Read CNT_HI → 0x01. Write CTRL 0x80 → STATUS 0x04, counts 0.

Source files
------------

// File: rtl/qoi_stream_port.sv
// QOI output window port: CPU pushes encoded bytes into a FIFO that drains on a valid/ready stream,
// with byte count, end-marker tagging (m_last) and optional done interrupt (QOI_STREAM_PORT_IRQ_EN).
module qoi_stream_port #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  shadow_q, shadow_d, rdata_q, rdata_d;
  logic [2:0]  run_q, run_d;
  logic        done_q, done_d, ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic        push_req, ctrl_wr, flush, empty, full, accept, pop, last_flag;
  logic [8:0]  head;

  always_comb begin
    push_req  = cs & we & (addr == 2'd0);
    ctrl_wr   = cs & we & (addr == 2'd1);
    flush     = ctrl_wr & wdata[7];
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // full is judged on pre-edge state, so a same-cycle pop never makes room for a push
    accept    = push_req & ~full;
    pop       = ~empty & m_ready & ~flush;
    head      = mem_q[rd_ptr_q[AW-1:0]];
    last_flag = (wdata == 8'h01) && (run_q == 3'd7);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    run_d    = run_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + 16'd1;
      if (wdata != 8'h00)    run_d = 3'd0;
      else if (run_q != 3'd7) run_d = run_q + 3'd1;
    end
    if (push_req & full) ovf_d = 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (head[8]) done_d = 1'b1;
    end

    if (cs & ~we) begin
      case (addr)
        2'd0: rdata_d = 8'h00;
        2'd1: rdata_d = {irq_en_q, 2'b00, ovf_q, done_q, empty, full, 1'b0};
        2'd2: begin
          rdata_d  = count_q[7:0];
          shadow_d = count_q[15:8];
        end
        default: rdata_d = shadow_q;
      endcase
    end

    if (ctrl_wr) irq_en_d = wdata[0];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 16'd0;
      run_d    = 3'd0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      shadow_d = 8'h00;
    end
    // done_q (not done_d) so irq rises the cycle after done sets
    irq_d = irq_en_d & done_q & ~flush;
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {last_flag, wdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 16'd0;
      run_q    <= 3'd0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      shadow_q <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      run_q    <= run_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign m_valid = ~empty;
  assign m_data  = empty ? 8'h00 : head[7:0];
  assign m_last  = ~empty & head[8];
`ifdef QOI_STREAM_PORT_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_qoi_stream_port.sv
// Directed bench for qoi_stream_port: register reads, streaming, overflow, end marker, count shadow.
module tb_qoi_stream_port;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0, we = 1'b0, m_ready = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata, m_data;
  logic       m_valid, m_last, irq;
  int checks = 0, errors = 0;
  logic [7:0] rd;

`ifdef QOI_STREAM_PORT_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  qoi_stream_port #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    step();
    cs = 1'b0;
    d = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_last_stream [10];
    #23 reset = 1'b0;
    step();
    // reset state
    chk("rst_rdata", {8'h0, rdata}, 16'h0000);
    chk("rst_valid", {15'h0, m_valid}, 16'h0000);
    chk("rst_mdata", {8'h0, m_data}, 16'h0000);
    chk("rst_last", {15'h0, m_last}, 16'h0000);
    chk("rst_irq", {15'h0, irq}, 16'h0000);
    cpu_rd(2'd1, rd); chk("rst_status", {8'h0, rd}, 16'h0004);
    cpu_rd(2'd2, rd); chk("rst_cnt_lo", {8'h0, rd}, 16'h0000);
    cpu_rd(2'd3, rd); chk("rst_cnt_hi", {8'h0, rd}, 16'h0000);

    // two-byte stream with back-pressure
    cpu_wr(2'd0, 8'hAA);
    cpu_wr(2'd0, 8'hBB);
    chk("bp_valid", {15'h0, m_valid}, 16'h0001);
    chk("bp_data0", {8'h0, m_data}, 16'h00AA);
    step();
    chk("bp_hold", {8'h0, m_data}, 16'h00AA);
    m_ready = 1'b1;
    step();
    chk("bp_data1", {8'h0, m_data}, 16'h00BB);
    step();
    chk("bp_drained", {15'h0, m_valid}, 16'h0000);
    m_ready = 1'b0;
    cpu_rd(2'd2, rd); chk("bp_cnt_lo", {8'h0, rd}, 16'h0002);

    // overflow: 17 pushes into 16 entries
    cpu_wr(2'd1, 8'h80);
    for (int i = 0; i < 17; i++) cpu_wr(2'd0, 8'h30 + 8'(i));
    cpu_rd(2'd1, rd); chk("ovf_status", {8'h0, rd}, 16'h0012);
    cpu_rd(2'd2, rd); chk("ovf_cnt_lo", {8'h0, rd}, 16'h0010);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_stream", {7'h0, m_valid, m_data}, {8'h01, 8'h30 + 8'(i)});
      step();
    end
    chk("ovf_no17th", {15'h0, m_valid}, 16'h0000);
    m_ready = 1'b0;

    // end marker with 8 zeros, irq enabled
    cpu_wr(2'd1, 8'h81);
    exp_last_stream[0] = 8'h10;
    for (int i = 1; i < 9; i++) exp_last_stream[i] = 8'h00;
    exp_last_stream[9] = 8'h01;
    for (int i = 0; i < 10; i++) cpu_wr(2'd0, exp_last_stream[i]);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("eom_stream", {7'h0, m_last, m_data}, {7'h0, (i == 9), exp_last_stream[i]});
      step();
    end
    m_ready = 1'b0;
    chk("eom_irq_early", {15'h0, irq}, 16'h0000);
    cpu_rd(2'd1, rd); chk("eom_status", {8'h0, rd}, 16'h008C);
    chk("eom_irq", {15'h0, irq}, {15'h0, IRQ_EXP});
    cpu_wr(2'd1, 8'h00);
    chk("eom_irq_off", {15'h0, irq}, 16'h0000);

    // near-miss markers: 6 zeros then 01; 7 zeros, 05, 01
    cpu_wr(2'd1, 8'h80);
    for (int i = 0; i < 6; i++) cpu_wr(2'd0, 8'h00);
    cpu_wr(2'd0, 8'h01);
    for (int i = 0; i < 7; i++) cpu_wr(2'd0, 8'h00);
    cpu_wr(2'd0, 8'h05);
    cpu_wr(2'd0, 8'h01);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("miss_last", {14'h0, m_valid, m_last}, 16'h0002);
      step();
    end
    m_ready = 1'b0;
    cpu_rd(2'd1, rd); chk("miss_status", {8'h0, rd}, 16'h0004);

    // count shadow across the 0x00FF -> 0x0100 carry
    cpu_wr(2'd1, 8'h80);
    m_ready = 1'b1;
    for (int i = 0; i < 255; i++) cpu_wr(2'd0, 8'hAA);
    cpu_rd(2'd2, rd); chk("cnt_lo_ff", {8'h0, rd}, 16'h00FF);
    cpu_wr(2'd0, 8'h77);
    cpu_rd(2'd3, rd); chk("cnt_hi_shadow", {8'h0, rd}, 16'h0000);
    cpu_rd(2'd2, rd); chk("cnt_lo_00", {8'h0, rd}, 16'h0000);
    cpu_rd(2'd3, rd); chk("cnt_hi_01", {8'h0, rd}, 16'h0001);
    cpu_wr(2'd1, 8'h80);
    cpu_rd(2'd1, rd); chk("flush_status", {8'h0, rd}, 16'h0004);
    cpu_rd(2'd2, rd); chk("flush_cnt_lo", {8'h0, rd}, 16'h0000);
    cpu_rd(2'd3, rd); chk("flush_cnt_hi", {8'h0, rd}, 16'h0000);
    m_ready = 1'b0;

    // flush discards a pending byte
    cpu_wr(2'd0, 8'h55);
    chk("fl_pending", {7'h0, m_valid, m_data}, 16'h0155);
    cpu_wr(2'd1, 8'h80);
    chk("fl_dropped", {15'h0, m_valid}, 16'h0000);

    // async reset mid-stream
    cpu_wr(2'd0, 8'h66);
    reset = 1'b1;
    #1;
    chk("arst_valid", {7'h0, m_valid, m_data}, 16'h0000);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
